gpio_log_reader: RTL

- GPIO command initiator that drains the BRAM capture log over the 32-bit GPIO register-file interface, doing in hardware what firmware does through the MicroBlaze GPIO.
- On start it arms a capture, polls for memory-full, then reads back each log address and presents every 32-bit word on a valid/ready stream.
- Drives the register file's i_gpio bus and samples its o_gpio bus, with no firmware involved.

---
 rtl/gpio_log_reader.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/gpio_log_reader.sv
// Drains the BRAM capture log through the GPIO register-file bus: arms a capture,
// polls for mem-full, then reads every log word back onto a valid/ready stream.
module gpio_log_reader #(
  parameter int          NB_GPIOS     = 32,
  parameter int          NB_ADDR      = 15,
  parameter int          SETUP_CYC    = 2,
  parameter int          STROBE_CYC   = 2,
  parameter int          WAIT_CYC     = 4,
  parameter int          POLL_MAX     = 1024,
  parameter logic [7:0]  CMD_RUN_LOG  = 8'h05,
  parameter logic [7:0]  CMD_MEM_STAT = 8'h06,
  parameter logic [7:0]  CMD_READ_LOG = 8'h07
) (
  input  logic                clk,
  input  logic                i_rstn,
  input  logic                i_start,
  input  logic [NB_ADDR:0]    i_num_words,
  output logic [NB_GPIOS-1:0] o_gpio,
  input  logic [NB_GPIOS-1:0] i_gpio,
  output logic [NB_GPIOS-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_timeout
);

  localparam int DW    = NB_GPIOS - 9;
  localparam int MAXC0 = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int MAXC  = (MAXC0 > WAIT_CYC) ? MAXC0 : WAIT_CYC;
  localparam int CW    = $clog2(MAXC + 1);
  localparam int PW    = $clog2(POLL_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_POLL, S_READ, S_OUT} state_t;
  typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_STROBE, PH_WAIT} phase_t;

  state_t                state_reg, state_next;
  phase_t                phase_reg, phase_next;
  logic [CW-1:0]         cyc_reg, cyc_next;
  logic [NB_ADDR:0]      addr_reg, addr_next;
  logic [NB_ADDR:0]      num_reg, num_next;
  logic [PW-1:0]         poll_reg, poll_next;
  logic [NB_GPIOS-1:0]   data_reg, data_next;
  logic                  valid_reg, valid_next;
  logic                  done_reg, done_next;
  logic                  timeout_reg, timeout_next;

  logic                  in_txn;
  logic                  txn_last;
  logic [7:0]            cmd_sel;
  logic [DW-1:0]         data_sel;

  always_ff @(posedge clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg   <= S_IDLE;
      phase_reg   <= PH_GAP;
      cyc_reg     <= '0;
      addr_reg    <= '0;
      num_reg     <= '0;
      poll_reg    <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      cyc_reg     <= cyc_next;
      addr_reg    <= addr_next;
      num_reg     <= num_next;
      poll_reg    <= poll_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      done_reg    <= done_next;
      timeout_reg <= timeout_next;
    end
  end

  assign in_txn   = (state_reg == S_ARM) || (state_reg == S_POLL) || (state_reg == S_READ);
  assign txn_last = in_txn && (phase_reg == PH_WAIT) && (cyc_reg == CW'(WAIT_CYC - 1));

  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    cyc_next     = cyc_reg;
    addr_next    = addr_reg;
    num_next     = num_reg;
    poll_next    = poll_reg;
    data_next    = data_reg;
    valid_next   = valid_reg;
    done_next    = 1'b0;
    timeout_next = timeout_reg;

    // Each transaction opens with one idle cycle so the strobe never spans two commands.
    if (in_txn) begin
      case (phase_reg)
        PH_GAP: begin
          phase_next = PH_SETUP;
          cyc_next   = '0;
        end
        PH_SETUP: begin
          if (cyc_reg == CW'(SETUP_CYC - 1)) begin
            phase_next = PH_STROBE;
            cyc_next   = '0;
          end else begin
            cyc_next = cyc_reg + CW'(1);
          end
        end
        PH_STROBE: begin
          if (cyc_reg == CW'(STROBE_CYC - 1)) begin
            phase_next = PH_WAIT;
            cyc_next   = '0;
          end else begin
            cyc_next = cyc_reg + CW'(1);
          end
        end
        default: begin
          if (txn_last) begin
            phase_next = PH_GAP;
            cyc_next   = '0;
          end else begin
            cyc_next = cyc_reg + CW'(1);
          end
        end
      endcase
    end

    case (state_reg)
      S_IDLE: begin
        if (i_start) begin
          timeout_next = 1'b0;
          if (i_num_words == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = S_ARM;
            num_next   = i_num_words;
            poll_next  = '0;
            phase_next = PH_GAP;
            cyc_next   = '0;
          end
        end
      end
      S_ARM: begin
        if (txn_last) state_next = S_POLL;
      end
      S_POLL: begin
        if (txn_last) begin
          poll_next = poll_reg + PW'(1);
          if (i_gpio[0]) begin
            addr_next  = '0;
            state_next = S_READ;
          end else if (poll_reg + PW'(1) == PW'(POLL_MAX)) begin
            timeout_next = 1'b1;
            done_next    = 1'b1;
            state_next   = S_IDLE;
          end
        end
      end
      S_READ: begin
        if (txn_last) begin
          data_next  = i_gpio;
          valid_next = 1'b1;
          state_next = S_OUT;
        end
      end
      S_OUT: begin
        if (i_ready) begin
          valid_next = 1'b0;
          addr_next  = addr_reg + 1'b1;
          if (addr_reg + 1'b1 == num_reg) begin
            done_next  = 1'b1;
            state_next = S_IDLE;
          end else begin
            state_next = S_READ;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_sel  = 8'h00;
    data_sel = '0;
    case (state_reg)
      S_ARM: begin
        cmd_sel  = CMD_RUN_LOG;
        data_sel = DW'(1);
      end
      S_POLL: cmd_sel = CMD_MEM_STAT;
      S_READ: begin
        cmd_sel  = CMD_READ_LOG;
        data_sel = DW'(addr_reg[NB_ADDR-1:0]);
      end
      default: begin
        cmd_sel  = 8'h00;
        data_sel = '0;
      end
    endcase
  end

  // Decoded straight from registers so the async reset clears the strobe at once.
  assign o_gpio    = (in_txn && phase_reg != PH_GAP)
                     ? {cmd_sel, (phase_reg == PH_STROBE), data_sel}
                     : '0;
  assign o_data    = data_reg;
  assign o_valid   = valid_reg;
  assign o_busy    = (state_reg != S_IDLE);
  assign o_done    = done_reg;
  assign o_timeout = timeout_reg;

endmodule
